decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised, registered instruction-decode stage for the 32-bit MIPS-style datapath.
- Sits between the fetch stage and the register file/ALU. Accepts one instruction plus its PC per valid/ready handshake and classifies the opcode internally, so no external is_branch/add_imm/load_word/store_word strobes are needed.
- Extracts all fields, extends the immediate and computes branch/jump targets.
- Inserts a one-cycle bubble on load-use hazards and supports pipeline flush.

Parameters:
- DATA_W, 32, width of extended immediate (32 or 64)
- PC_W, 32, PC width (legal range 28..32)
- REG_ADDR_W, 5, register index width (fields still taken from MIPS bit positions; upper bits zero-padded if >5)
- INTERLOCK_EN, 1, 1 = load-use bubble insertion enabled; 0 = never stall
- STALL_CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard the output register and pending hazard state
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts the bundle
- out_op  out  6  opcode [31:26]
- out_rs  out  REG_ADDR_W  [25:21]
- out_rt  out  REG_ADDR_W  [20:16]
- out_dst  out  REG_ADDR_W  write-back register index
- out_funct  out  6  [5:0]
- out_shamt  out  5  [10:6]
- out_imm  out  DATA_W  extended immediate
- out_target  out  PC_W  branch/jump target
- out_pc  out  PC_W  registered in_pc
- out_class  out  3  instruction class
- out_reg_write  out  1  instruction writes a register
- out_mem_read  out  1  instruction reads memory
- out_mem_write  out  1  instruction writes memory
- out_illegal  out  1  unknown opcode
- stall_count  out  STALL_CNT_W  number of bubbles inserted

Behaviour:
- Opcodes and classes:
  - 0x00 R-type, class 0
  - 0x08 ADDI, class 1
  - 0x0C ANDI, class 1
  - 0x0D ORI, class 1
  - 0x23 LW, class 2
  - 0x2B SW, class 3
  - 0x04 BEQ, class 4
  - 0x02 J, class 5
  - any other opcode: class 7, out_illegal=1, reg_write/mem_read/mem_write all 0
- out_dst:
  - R-type: rd [15:11]
  - class 1 and LW: rt
  - all other classes: 0
- out_reg_write = 1 only when out_dst != 0.
- out_imm:
  - ADDI, LW, SW, BEQ: sign-extended imm[15:0]
  - ANDI, ORI: zero-extended imm[15:0]
  - all other opcodes: 0
- out_target:
  - BEQ: in_pc + 4 + (sext(imm) << 2), truncated to PC_W
  - J: {(in_pc+4)[PC_W-1:28], instr[25:0], 2'b00}
  - all other opcodes: 0
- Handshake:
  - load_en = !out_valid || out_ready.
  - Output register updates only when load_en=1.
  - in_ready = load_en && !hazard && !flush && !rst.
  - Transfer occurs when in_valid && in_ready.
  - Latency is 1 cycle: a transfer in cycle N gives out_valid=1 with the decoded fields in cycle N+1.
- Back-pressure: when out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Hazard tracking:
  - State is ld_pend (1 bit) and ld_dst.
  - On a transfer: ld_pend <= (class==LW && rt!=0); ld_dst <= rt.
  - hazard = INTERLOCK_EN && in_valid && ld_pend && (in.rs==ld_dst || (in.class in {R, SW, BEQ} && in.rt==ld_dst)).
- Bubble:
  - When load_en && hazard: out_valid <= 0, ld_pend <= 0, stall_count += 1 (saturating at all-ones).
  - The instruction is not consumed and is accepted in the next load_en cycle.
  - Exactly one bubble per load-use pair.
- When load_en && !in_valid && !hazard: out_valid <= 0, ld_pend <= 0.
- Flush:
  - out_valid <= 0 and ld_pend <= 0. The presented instruction is not consumed.
  - Flush overrides hazard and back-pressure.
  - stall_count is unchanged by flush.
- Reset:
  - All outputs 0, ld_pend=0, stall_count=0.
  - rst has priority over flush.
  - Reset mid-stall drops the held bundle.

Test Plan:
- Reset then in_instr=0x2128FFFC (ADDI $8,$9,-4), out_ready=1 -> next cycle: out_valid=1, rs=9, rt=8, dst=8, imm=0xFFFFFFFC, class=1, reg_write=1.
- LW 0x8C620000 followed by ADD 0x00452020 back-to-back -> LW issued; one cycle with out_valid=0 and in_ready=0; ADD issued next cycle with dst=4; stall_count=1. Repeat with INTERLOCK_EN=0 -> no bubble, stall_count=0.
- BEQ 0x10220003 at pc 0x100 -> out_target=0x110, class=4, reg_write=0. J 0x08000040 at pc 0x10000000 -> out_target=0x10000100.
- Accept ORI, then hold out_ready=0 for 3 cycles -> all outputs stable, in_ready=0; out_ready=1 -> next instruction is accepted that cycle.
- LW then dependent ADD with flush asserted during the bubble cycle -> out_valid=0, ld_pend cleared; ADD is then accepted without a further bubble.
- Opcode 0x3F -> out_illegal=1, class=7, reg_write/mem_read/mem_write=0. Assert rst mid-stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/decode_stage.sv
// Registered instruction-decode stage for a 32-bit MIPS-style datapath.
// Classifies the opcode, extracts the fields, extends the immediate and
// computes branch/jump targets. A one-cycle bubble is inserted when an
// instruction depends on the load issued directly before it.
module decode_stage #(
    parameter int DATA_W       = 32,
    parameter int PC_W         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int INTERLOCK_EN = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5:0]             out_op,
    output logic [REG_ADDR_W-1:0]  out_rs,
    output logic [REG_ADDR_W-1:0]  out_rt,
    output logic [REG_ADDR_W-1:0]  out_dst,
    output logic [5:0]             out_funct,
    output logic [4:0]             out_shamt,
    output logic [DATA_W-1:0]      out_imm,
    output logic [PC_W-1:0]        out_target,
    output logic [PC_W-1:0]        out_pc,
    output logic [2:0]             out_class,
    output logic                   out_reg_write,
    output logic                   out_mem_read,
    output logic                   out_mem_write,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_IMM = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_J   = 3'd5,
        CLS_ILL = 3'd7
    } class_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;

    // Raw fields of the presented instruction; register indices zero-padded.
    logic [5:0]            op;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]     imm_sext, imm_zext;
    logic [PC_W-1:0]       pc_plus4, br_target, j_target;

    assign op       = in_instr[31:26];
    assign rs       = REG_ADDR_W'(in_instr[25:21]);
    assign rt       = REG_ADDR_W'(in_instr[20:16]);
    assign rd       = REG_ADDR_W'(in_instr[15:11]);
    assign imm_sext = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
    assign imm_zext = {{(DATA_W-16){1'b0}}, in_instr[15:0]};
    assign pc_plus4 = in_pc + PC_W'(4);
    assign br_target = pc_plus4 + {{(PC_W-18){in_instr[15]}}, in_instr[15:0], 2'b00};

    // Jump keeps the region bits of pc+4 above bit 27 and replaces the rest.
    always_comb begin
        j_target       = pc_plus4;
        j_target[27:0] = {in_instr[25:0], 2'b00};
    end

    // Decoded attributes of the presented instruction.
    class_e                dec_class;
    logic [REG_ADDR_W-1:0] dec_dst;
    logic [DATA_W-1:0]     dec_imm;
    logic [PC_W-1:0]       dec_target;

    // Opcode classification, destination, immediate and target selection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        dec_class  = CLS_ILL;
        dec_dst    = '0;
        dec_imm    = '0;
        dec_target = '0;
        case (op)
            OP_R: begin
                dec_class = CLS_R;
                dec_dst   = rd;
            end
            OP_ADDI: begin
                dec_class = CLS_IMM;
                dec_dst   = rt;
                dec_imm   = imm_sext;
            end
            OP_ANDI, OP_ORI: begin
                dec_class = CLS_IMM;
                dec_dst   = rt;
                dec_imm   = imm_zext;
            end
            OP_LW: begin
                dec_class = CLS_LW;
                dec_dst   = rt;
                dec_imm   = imm_sext;
            end
            OP_SW: begin
                dec_class = CLS_SW;
                dec_imm   = imm_sext;
            end
            OP_BEQ: begin
                dec_class  = CLS_BEQ;
                dec_imm    = imm_sext;
                dec_target = br_target;
            end
            OP_J: begin
                dec_class  = CLS_J;
                dec_target = j_target;
            end
            default: ;
        endcase
    end

    // Load-use hazard tracking and handshake.
    logic                  ld_pend;
    logic [REG_ADDR_W-1:0] ld_dst;
    logic                  uses_rt;
    logic                  hazard;
    logic                  load_en;
    logic                  transfer;

    assign uses_rt  = (dec_class == CLS_R) || (dec_class == CLS_SW) || (dec_class == CLS_BEQ);
    assign hazard   = (INTERLOCK_EN != 0) && in_valid && ld_pend &&
                      ((rs == ld_dst) || (uses_rt && (rt == ld_dst)));
    assign load_en  = !out_valid || out_ready;
    assign in_ready = load_en && !hazard && !flush && !rst;
    assign transfer = in_valid && in_ready;

    // Output register, hazard state and bubble counter; reset beats flush,
    // flush beats hazard and back-pressure.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            out_valid     <= 1'b0;
            out_op        <= '0;
            out_rs        <= '0;
            out_rt        <= '0;
            out_dst       <= '0;
            out_funct     <= '0;
            out_shamt     <= '0;
            out_imm       <= '0;
            out_target    <= '0;
            out_pc        <= '0;
            out_class     <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            out_mem_write <= 1'b0;
            out_illegal   <= 1'b0;
            ld_pend       <= 1'b0;
            ld_dst        <= '0;
            stall_count   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ld_pend   <= 1'b0;
        end else if (load_en) begin
            if (hazard) begin
                out_valid <= 1'b0;
                ld_pend   <= 1'b0;
                if (stall_count != '1) begin
                    stall_count <= stall_count + STALL_CNT_W'(1);
                end
            end else if (transfer) begin
                out_valid     <= 1'b1;
                out_op        <= op;
                out_rs        <= rs;
                out_rt        <= rt;
                out_dst       <= dec_dst;
                out_funct     <= in_instr[5:0];
                out_shamt     <= in_instr[10:6];
                out_imm       <= dec_imm;
                out_target    <= dec_target;
                out_pc        <= in_pc;
                out_class     <= dec_class;
                out_reg_write <= (dec_dst != '0);
                out_mem_read  <= (dec_class == CLS_LW);
                out_mem_write <= (dec_class == CLS_SW);
                out_illegal   <= (dec_class == CLS_ILL);
                ld_pend       <= (dec_class == CLS_LW) && (rt != '0);
                ld_dst        <= rt;
            end else begin
                out_valid <= 1'b0;
                ld_pend   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by a
// randomized instruction stream checked against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid;
    logic [5:0]  out_op, out_funct;
    logic [4:0]  out_rs, out_rt, out_dst, out_shamt;
    logic [31:0] out_imm, out_target, out_pc;
    logic [2:0]  out_class;
    logic        out_reg_write, out_mem_read, out_mem_write, out_illegal;
    logic [15:0] stall_count;

    logic        ni_in_ready, ni_out_valid;
    logic [5:0]  ni_out_op, ni_out_funct;
    logic [4:0]  ni_out_rs, ni_out_rt, ni_out_dst, ni_out_shamt;
    logic [31:0] ni_out_imm, ni_out_target, ni_out_pc;
    logic [2:0]  ni_out_class;
    logic        ni_out_reg_write, ni_out_mem_read, ni_out_mem_write, ni_out_illegal;
    logic [15:0] ni_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.INTERLOCK_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst),
        .out_funct(out_funct), .out_shamt(out_shamt), .out_imm(out_imm),
        .out_target(out_target), .out_pc(out_pc), .out_class(out_class),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_illegal(out_illegal), .stall_count(stall_count)
    );

    decode_stage #(.INTERLOCK_EN(0)) dut_ni (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ni_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ni_out_valid), .out_ready(out_ready),
        .out_op(ni_out_op), .out_rs(ni_out_rs), .out_rt(ni_out_rt), .out_dst(ni_out_dst),
        .out_funct(ni_out_funct), .out_shamt(ni_out_shamt), .out_imm(ni_out_imm),
        .out_target(ni_out_target), .out_pc(ni_out_pc), .out_class(ni_out_class),
        .out_reg_write(ni_out_reg_write), .out_mem_read(ni_out_mem_read),
        .out_mem_write(ni_out_mem_write), .out_illegal(ni_out_illegal),
        .stall_count(ni_stall_count)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs, rt, dst, shamt;
        logic [5:0]  funct;
        logic [31:0] imm, target;
        logic [2:0]  cls;
        logic        rw, mr, mw, ill;
    } exp_t;

    // Reference decode written straight from the opcode table with arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   off;
        e       = '0;
        e.op    = 6'(ins >> 26);
        e.rs    = 5'(ins >> 21);
        e.rt    = 5'(ins >> 16);
        e.shamt = 5'(ins >> 6);
        e.funct = 6'(ins);
        off     = int'($signed(ins[15:0]));
        case (e.op)
            6'h00: begin e.cls = 3'd0; e.dst = 5'(ins >> 11); end
            6'h08: begin e.cls = 3'd1; e.dst = e.rt; e.imm = 32'(off); end
            6'h0C, 6'h0D: begin e.cls = 3'd1; e.dst = e.rt; e.imm = ins & 32'hFFFF; end
            6'h23: begin e.cls = 3'd2; e.dst = e.rt; e.imm = 32'(off); e.mr = 1'b1; end
            6'h2B: begin e.cls = 3'd3; e.imm = 32'(off); e.mw = 1'b1; end
            6'h04: begin e.cls = 3'd4; e.imm = 32'(off); e.target = pc + 32'd4 + 32'(off * 4); end
            6'h02: begin
                e.cls    = 3'd5;
                e.target = ((pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
            end
            default: begin e.cls = 3'd7; e.ill = 1'b1; end
        endcase
        e.rw = (e.dst != 5'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bundle(input string tag, input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e = ref_decode(ins, pc);
        check({tag, "_valid"},  out_valid,     1);
        check({tag, "_op"},     out_op,        e.op);
        check({tag, "_rs"},     out_rs,        e.rs);
        check({tag, "_rt"},     out_rt,        e.rt);
        check({tag, "_dst"},    out_dst,       e.dst);
        check({tag, "_funct"},  out_funct,     e.funct);
        check({tag, "_shamt"},  out_shamt,     e.shamt);
        check({tag, "_imm"},    out_imm,       e.imm);
        check({tag, "_target"}, out_target,    e.target);
        check({tag, "_pc"},     out_pc,        pc);
        check({tag, "_class"},  out_class,     e.cls);
        check({tag, "_rw"},     out_reg_write, e.rw);
        check({tag, "_mr"},     out_mem_read,  e.mr);
        check({tag, "_mw"},     out_mem_write, e.mw);
        check({tag, "_ill"},    out_illegal,   e.ill);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [9];
        logic [5:0] op;
        int         k;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
        k   = int'($urandom_range(9));
        op  = (k == 9) ? 6'($urandom_range(63)) : ops[k];
        return {op, 5'($urandom_range(3)), 5'($urandom_range(3)), 16'($urandom)};
    endfunction

    localparam logic [31:0] I_ADDI = 32'h2128_FFFC;
    localparam logic [31:0] I_LW   = 32'h8C62_0000;
    localparam logic [31:0] I_ADD  = 32'h0045_2020;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_J    = 32'h0800_0040;
    localparam logic [31:0] I_ORI  = 32'h34A5_80F0;
    localparam logic [31:0] I_ILL  = 32'hFC00_0000;

    initial begin
        exp_t        e;
        logic [31:0] ins, pc;
        logic        prev_ld, bubble, dep_rt;
        logic [4:0]  prev_rt;
        int          exp_stalls;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        exp_stalls = 0;
        tick();
        tick();
        check("rst_in_ready",  in_ready,    0);
        check("rst_out_valid", out_valid,   0);
        check("rst_out_op",    out_op,      0);
        check("rst_out_imm",   out_imm,     0);
        check("rst_out_pc",    out_pc,      0);
        check("rst_stalls",    stall_count, 0);
        rst = 1'b0;

        // ADDI $8,$9,-4
        present(I_ADDI, 32'h0);
        check("addi_ready", in_ready, 1);
        tick();
        check("addi_rs",  out_rs,        9);
        check("addi_rt",  out_rt,        8);
        check("addi_dst", out_dst,       8);
        check("addi_imm", out_imm,       32'hFFFF_FFFC);
        check("addi_cls", out_class,     1);
        check("addi_rw",  out_reg_write, 1);
        check_bundle("addi", I_ADDI, 32'h0);

        // LW then dependent ADD: one bubble with interlock, none without
        present(I_LW, 32'h200);
        tick();
        check_bundle("lw", I_LW, 32'h200);
        present(I_ADD, 32'h204);
        check("lu_ready",    in_ready,    0);
        check("lu_ni_ready", ni_in_ready, 1);
        tick();
        exp_stalls++;
        check("lu_bubble",   out_valid,      0);
        check("lu_stalls",   stall_count,    exp_stalls);
        check("lu_ready2",   in_ready,       1);
        check("ni_valid",    ni_out_valid,   1);
        check("ni_dst",      ni_out_dst,     4);
        check("ni_stalls",   ni_stall_count, 0);
        tick();
        check_bundle("add", I_ADD, 32'h204);
        check("add_dst",     out_dst,        4);
        check("add_stalls",  stall_count,    exp_stalls);
        check("ni_stalls2",  ni_stall_count, 0);

        // Branch and jump targets
        present(I_BEQ, 32'h100);
        tick();
        check("beq_target", out_target,    32'h110);
        check("beq_cls",    out_class,     4);
        check("beq_rw",     out_reg_write, 0);
        check_bundle("beq", I_BEQ, 32'h100);
        present(I_J, 32'h1000_0000);
        tick();
        check("j_target", out_target, 32'h1000_0100);
        check_bundle("j", I_J, 32'h1000_0000);

        // Back-pressure holds the bundle for three cycles
        present(I_ORI, 32'h300);
        tick();
        check_bundle("ori", I_ORI, 32'h300);
        out_ready = 1'b0;
        present(I_ADDI, 32'h304);
        check("bp_ready0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_imm",   out_imm,   32'h0000_80F0);
            check("bp_pc",    out_pc,    32'h300);
            check("bp_ready", in_ready,  0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check_bundle("bp_next", I_ADDI, 32'h304);

        // Flush during the bubble cycle clears the pending load
        present(I_LW, 32'h400);
        tick();
        check_bundle("fl_lw", I_LW, 32'h400);
        present(I_ADD, 32'h404);
        flush = 1'b1;
        #1;
        check("fl_ready", in_ready, 0);
        tick();
        check("fl_valid",  out_valid,   0);
        check("fl_stalls", stall_count, exp_stalls);
        flush = 1'b0;
        #1;
        check("fl_ready2", in_ready, 1);
        tick();
        check_bundle("fl_add", I_ADD, 32'h404);
        check("fl_stalls2", stall_count, exp_stalls);

        // Illegal opcode
        present(I_ILL, 32'h500);
        tick();
        check("ill_flag", out_illegal, 1);
        check("ill_cls",  out_class,   7);
        check_bundle("ill", I_ILL, 32'h500);

        // Randomized stream with idle and back-pressure gaps
        in_valid = 1'b0;
        tick();
        prev_ld = 1'b0;
        prev_rt = '0;
        for (int n = 0; n < 300; n++) begin
            ins    = rand_instr();
            pc     = $urandom & 32'hFFFF_FFFC;
            e      = ref_decode(ins, pc);
            dep_rt = (e.cls == 3'd0) || (e.cls == 3'd3) || (e.cls == 3'd4);
            bubble = prev_ld && ((e.rs == prev_rt) || (dep_rt && (e.rt == prev_rt)));
            present(ins, pc);
            if (bubble) begin
                check("rnd_haz_ready", in_ready, 0);
                tick();
                check("rnd_bubble", out_valid, 0);
                exp_stalls++;
            end
            check("rnd_ready", in_ready, 1);
            tick();
            check_bundle("rnd", ins, pc);
            prev_ld = (e.cls == 3'd2) && (e.rt != 5'd0);
            prev_rt = e.rt;
            case ($urandom_range(3))
                0: begin
                    in_valid = 1'b0;
                    tick();
                    check("rnd_idle", out_valid, 0);
                    prev_ld = 1'b0;
                end
                1: begin
                    in_valid  = 1'b0;
                    out_ready = 1'b0;
                    tick();
                    check("rnd_hold_valid", out_valid, 1);
                    check("rnd_hold_pc",    out_pc,    pc);
                    check("rnd_hold_ready", in_ready,  0);
                    out_ready = 1'b1;
                end
                default: ;
            endcase
        end
        check("rnd_stalls", stall_count, exp_stalls);

        // Reset in the middle of a stall drops everything
        present(I_LW, 32'h600);
        tick();
        present(I_ADD, 32'h604);
        rst = 1'b1;
        #1;
        check("rstm_ready", in_ready, 0);
        tick();
        check("rstm_valid",  out_valid,     0);
        check("rstm_op",     out_op,        0);
        check("rstm_dst",    out_dst,       0);
        check("rstm_target", out_target,    0);
        check("rstm_mr",     out_mem_read,  0);
        check("rstm_stalls", stall_count,   0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rstm_dropped", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
